// File: rtl/rs232_rx_pkg.sv
// Shared definitions for the RS-232 receive path: FSM state encoding,
// default line settings and the bit-period helper.
package rs232_rx_pkg;

  localparam int unsigned DEF_CLK_FREQ = 32'd50_000_000;
  localparam int unsigned DEF_BAUD     = 32'd115_200;
  localparam int unsigned DATA_BITS    = 32'd8;

  // Encoding is shared with the transmit side, so values are pinned.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for an asynchronous serial line; resets to the
// idle (high) level so no false start edge appears after reset.
module rs232_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronisation into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver, LSB first: mid-bit sampling from a falling start edge,
// one-cycle valid / framing-error strobes, no buffering.
module rs232_rx
  import rs232_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 32'd2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 32'd1);
  localparam logic [2:0]       IDX_LAST     = 3'(DATA_BITS - 32'd1);

  logic             rx_s;
  logic             rx_q_r;
  logic             fall_s;

  rx_state_e        state_r;
  rx_state_e        state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_nx_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nx_s;
  logic [7:0]       rx_data_r;
  logic [7:0]       data_nx_s;
  logic             valid_nx_s;
  logic             err_nx_s;
  logic             rx_valid_r;
  logic             frame_err_r;
  logic             busy_r;

  rs232_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rx),
    .sync_out (rx_s)
  );

  // History flop on the synchronized line for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q_r <= 1'b1;
    end else begin
      rx_q_r <= rx_s;
    end
  end

  // Only a high-to-low transition starts a frame; a held-low break does not.
  assign fall_s = rx_q_r & ~rx_s;

  // Next-state, counters, shift register and strobe decode
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    bit_idx_nx_s = bit_idx_r;
    shift_nx_s   = shift_r;
    data_nx_s    = rx_data_r;
    valid_nx_s   = 1'b0;
    err_nx_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF_LAST) begin
          cnt_nx_s = CNT_ZERO;
          if (!rx_s) begin
            bit_idx_nx_s = 3'd0;
            state_nx_s   = ST_DATA;
          end else begin
            state_nx_s   = ST_IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_nx_s   = CNT_ZERO;
          shift_nx_s = {rx_s, shift_r[7:1]};
          if (bit_idx_r == IDX_LAST) begin
            state_nx_s = ST_STOP;
          end else begin
            bit_idx_nx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop-bit so a zero-gap next start edge is caught.
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = ST_IDLE;
          if (rx_s) begin
            data_nx_s  = shift_r;
            valid_nx_s = 1'b1;
          end else begin
            err_nx_s   = 1'b1;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_nx_s   = CNT_ZERO;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, baud counter, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      bit_idx_r <= bit_idx_nx_s;
      shift_r   <= shift_nx_s;
    end
  end

  // Registered outputs; busy tracks the state being entered this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_data_r   <= data_nx_s;
      rx_valid_r  <= valid_nx_s;
      frame_err_r <= err_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed plus randomized bench for rs232_rx: a line driver serialises
// bytes and an event-level model predicts the strobes each frame should give.
module tb_rs232_rx;

  localparam int BIT_NS    = 8680;
  localparam int HALF_NS   = 4340;
  localparam int LAT_MIN   = 82480;
  localparam int LAT_MAX   = 82560;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Observed events: {is_frame_err, data}, plus the time of each valid strobe.
  logic [8:0] act_q[$];
  time        act_t[$];
  bit         both_seen = 1'b0;
  bit         busy_seen = 1'b0;

  // Model: expected events and the byte rx_data should be holding.
  logic [8:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  time        frame_t;

  always #10 clk = ~clk;

  rs232_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      act_q.push_back({1'b0, rx_data});
      act_t.push_back($time);
    end
    if (frame_err) act_q.push_back({1'b1, 8'h00});
    if (rx_valid && frame_err) both_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    #(BIT_NS);
  endtask

  // Serialise start, 8 data bits LSB first, and a stop bit of the given level.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    frame_t = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (stop_ok) begin
      exp_q.push_back({1'b0, b});
      exp_data = b;
    end else begin
      exp_q.push_back(9'h100);
    end
  endtask

  task automatic check_latency(input string tag);
    time d;
    if (act_t.size() == 0) begin
      check({tag, " strobe_seen"}, 32'd0, 32'd1);
    end else begin
      d = act_t[act_t.size() - 1] - frame_t;
      check({tag, " latency_ok"}, 32'(d >= LAT_MIN && d <= LAT_MAX), 32'd1);
    end
  endtask

  task automatic check_events(input string tag);
    check({tag, " count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0)
      check({tag, " event"}, 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    act_q.delete();
    act_t.delete();
    check({tag, " rx_data"}, rx_data, exp_data);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rok;

    #50;
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    #50 rst_n = 1'b1;
    #10000;
    check_events("idle");

    send_frame(8'hFF, 1'b1);
    check_latency("ff");
    check_events("ff");

    send_frame(8'h55, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("zero_gap strobes", act_t.size(), 32'd2);
    if (act_t.size() == 2)
      check("zero_gap spacing", 32'(act_t[1] - act_t[0]), 32'(11 * BIT_NS - BIT_NS));
    check_events("zero_gap");

    busy_seen = 1'b0;
    rx = 1'b0;
    #2000;
    rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch busy_pulse", busy_seen, 1'b1);
    check("glitch busy_end", busy, 1'b0);
    check_events("glitch");

    send_frame(8'h3C, 1'b0);
    #20000;
    check("break no_retrigger", busy, 1'b0);
    check_events("framing");
    rx = 1'b1;
    #(BIT_NS);
    send_frame(8'h81, 1'b1);
    check_events("after_framing");

    // Abort 0xF0 in the middle of data bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    #(HALF_NS);
    check("midframe busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_data = 8'h00;
    check("midreset rx_data", rx_data, 8'h00);
    check("midreset rx_valid", rx_valid, 1'b0);
    check("midreset frame_err", frame_err, 1'b0);
    check("midreset busy", busy, 1'b0);
    #99 rst_n = 1'b1;
    #(HALF_NS - 100);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    check("post_reset busy", busy, 1'b0);
    check_events("reset_mid");
    send_frame(8'h12, 1'b1);
    check_latency("after_reset");
    check_events("after_reset");

    for (int n = 0; n < 6; n++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 3) != 0);
      send_frame(rb, rok);
      if (!rok) begin
        rx = 1'b1;
        #(BIT_NS);
      end else begin
        #(BIT_NS * $urandom_range(0, 2));
      end
      check_events("random");
    end

    check("valid_err overlap", both_seen, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
